otbn_bignum_mul256_seq: RTL and testbench

Sequencer placed directly upstream of the OTBN bignum MAC. It expands one full 256x256-bit multiply request into the fixed 16-step MULQACC schedule. For each step it drives the MAC operation, enable, commit and predecode signals, then collects the shifted-out half-words from the MAC result into a 512-bit product. It is used by the controller for a hardware-accelerated multiply, and by DV as a MAC stimulus source.

---
 rtl/otbn_bignum_mul256_seq_pkg.sv | 61 ++++++
 rtl/otbn_bignum_mul256_seq.sv | 126 ++++++++++++
 tb/tb_otbn_bignum_mul256_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/otbn_bignum_mul256_seq_pkg.sv
// Shared types for the 256x256 MULQACC sequencer: the MAC interface structs
// and the fixed 16-step schedule.
package otbn_bignum_mul256_seq_pkg;

  localparam int WLEN     = 256;
  localparam int QWLEN    = WLEN / 4;
  localparam int NumSteps = 16;

  typedef struct packed {
    logic [WLEN-1:0] operand_a;
    logic [WLEN-1:0] operand_b;
    logic [1:0]      operand_a_qw_sel;
    logic [1:0]      operand_b_qw_sel;
    logic            wr_hw_sel_upper;
    logic [1:0]      pre_acc_shift_imm;
    logic            zero_acc;
    logic            shift_acc;
  } mac_bignum_operation_t;

  typedef struct packed {
    logic op_en;
    logic acc_rd_en;
  } mac_predec_bignum_t;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } mul256_state_e;

  typedef struct packed {
    logic [1:0] a_qw;
    logic [1:0] b_qw;
    logic [1:0] shift_imm;
    logic       zero_acc;
    logic       shift_acc;
    logic       wr_hw_sel_upper;
    logic       capture_en;
    logic [1:0] slot;
  } mul256_step_t;

  // Field order: a_qw, b_qw, shift_imm, zero_acc, shift_acc, upper, capture, slot.
  localparam mul256_step_t Mul256Schedule [NumSteps] = '{
    '{2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0},
    '{2'd1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0},
    '{2'd0, 2'd1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0},
    '{2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0},
    '{2'd1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0},
    '{2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0},
    '{2'd3, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0},
    '{2'd2, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0},
    '{2'd1, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0},
    '{2'd0, 2'd3, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1},
    '{2'd3, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0},
    '{2'd2, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0},
    '{2'd1, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0},
    '{2'd3, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0},
    '{2'd2, 2'd3, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2},
    '{2'd3, 2'd3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3}
  };

endpackage

// File: rtl/otbn_bignum_mul256_seq.sv
// Expands a 256x256 multiply into the 16-step MULQACC schedule on the bignum
// MAC and assembles the shifted-out half-words into a 512-bit product.
module otbn_bignum_mul256_seq
  import otbn_bignum_mul256_seq_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  stall_i,
  input  logic [WLEN-1:0]       operand_a_i,
  input  logic [WLEN-1:0]       operand_b_i,
  output mac_bignum_operation_t mac_operation_o,
  output logic                  mac_en_o,
  output logic                  mac_commit_o,
  output mac_predec_bignum_t    mac_predec_o,
  input  logic [WLEN-1:0]       mac_result_i,
  input  logic                  mac_intg_err_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [2*WLEN-1:0]     result_o
);

  mul256_state_e     state_q, state_d;
  logic [3:0]        step_q, step_d;
  logic [WLEN-1:0]   opa_q, opa_d;
  logic [WLEN-1:0]   opb_q, opb_d;
  logic [2*WLEN-1:0] result_q, result_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  mul256_step_t      cur_step;
  logic              commit;

  // Only the lower half-word of the MAC result is ever written back.
  logic unused_mac_result_upper;
  assign unused_mac_result_upper = ^mac_result_i[WLEN-1:2*QWLEN];

  assign cur_step = Mul256Schedule[step_q];

  always_comb begin
    state_d         = state_q;
    step_d          = step_q;
    opa_d           = opa_q;
    opb_d           = opb_q;
    result_d        = result_q;
    done_d          = 1'b0;
    err_d           = 1'b0;
    commit          = 1'b0;
    mac_operation_o = '0;
    mac_en_o        = 1'b0;
    mac_commit_o    = 1'b0;
    mac_predec_o    = '0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          step_d  = 4'd0;
          opa_d   = operand_a_i;
          opb_d   = operand_b_i;
        end
      end
      StRun: begin
        mac_en_o                          = 1'b1;
        mac_predec_o.op_en                = 1'b1;
        mac_predec_o.acc_rd_en            = ~cur_step.zero_acc;
        mac_operation_o.operand_a         = opa_q;
        mac_operation_o.operand_b         = opb_q;
        mac_operation_o.operand_a_qw_sel  = cur_step.a_qw;
        mac_operation_o.operand_b_qw_sel  = cur_step.b_qw;
        mac_operation_o.pre_acc_shift_imm = cur_step.shift_imm;
        mac_operation_o.zero_acc          = cur_step.zero_acc;
        mac_operation_o.shift_acc         = cur_step.shift_acc;
        mac_operation_o.wr_hw_sel_upper   = cur_step.wr_hw_sel_upper;
        commit       = ~stall_i & ~abort_i & ~mac_intg_err_i;
        mac_commit_o = commit;

        if (abort_i || mac_intg_err_i) begin
          // An integrity violation is an abort that is also reported.
          state_d = StIdle;
          step_d  = 4'd0;
          err_d   = mac_intg_err_i;
        end else if (commit) begin
          if (cur_step.capture_en) begin
            result_d[{cur_step.slot, 7'b0} +: 2*QWLEN] = mac_result_i[2*QWLEN-1:0];
          end
          if (step_q == 4'(NumSteps - 1)) begin
            state_d = StIdle;
            step_d  = 4'd0;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      step_q   <= 4'd0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy_o   = (state_q == StRun);
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_otbn_bignum_mul256_seq.sv
// Bench for the 256x256 multiply sequencer, driving a small behavioural model
// of the bignum MAC from the sequencer's outputs.
module tb_otbn_bignum_mul256_seq;
  import otbn_bignum_mul256_seq_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  start_i, abort_i, stall_i, intg_err;
  logic [WLEN-1:0]       operand_a_i, operand_b_i;
  mac_bignum_operation_t mac_op;
  logic                  mac_en, mac_commit;
  mac_predec_bignum_t    mac_predec;
  logic [WLEN-1:0]       mac_result;
  logic                  busy_o, done_o, err_o;
  logic [2*WLEN-1:0]     result_o;

  otbn_bignum_mul256_seq dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .stall_i         (stall_i),
    .operand_a_i     (operand_a_i),
    .operand_b_i     (operand_b_i),
    .mac_operation_o (mac_op),
    .mac_en_o        (mac_en),
    .mac_commit_o    (mac_commit),
    .mac_predec_o    (mac_predec),
    .mac_result_i    (mac_result),
    .mac_intg_err_i  (intg_err),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .result_o        (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC: qw product, pre-shift, accumulate, optional half-word shift.
  logic [63:0]  qa, qb;
  logic [127:0] mprod;
  logic [255:0] shifted, acc_in, adder, mac_acc_q;

  always_comb begin
    qa      = mac_op.operand_a[{mac_op.operand_a_qw_sel, 6'b0} +: 64];
    qb      = mac_op.operand_b[{mac_op.operand_b_qw_sel, 6'b0} +: 64];
    mprod   = {64'b0, qa} * {64'b0, qb};
    shifted = {128'b0, mprod} << {mac_op.pre_acc_shift_imm, 6'b0};
    acc_in  = mac_op.zero_acc ? '0 : mac_acc_q;
    adder   = acc_in + shifted;
  end
  assign mac_result = adder;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mac_acc_q <= '0;
    else if (mac_en && mac_commit)
      mac_acc_q <= mac_op.shift_acc ? {128'b0, adder[255:128]} : adder;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-run observations.
  int   r_done_cyc, r_idle_cyc, r_commits, r_stall_commits, r_dones, r_errs;
  logic r_rd0, r_rd1;

  // Cycle 0 presents start; every later cycle is sampled 1ns after the falling edge.
  task automatic run_mul(input logic [255:0] a, input logic [255:0] b,
                         input int stall_at, input int stall_len,
                         input int abort_at, input int err_at, input int restart_at);
    r_done_cyc = -1; r_idle_cyc = -1; r_commits = 0; r_stall_commits = 0;
    r_dones = 0; r_errs = 0; r_rd0 = 1'bx; r_rd1 = 1'bx;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      start_i     = (c == 0) || (c == restart_at);
      operand_a_i = (c == 0) ? a : ~a;
      operand_b_i = (c == 0) ? b : ~b;
      stall_i     = (c >= stall_at) && (c < stall_at + stall_len);
      abort_i     = (c == abort_at);
      intg_err    = (c == err_at);
      #1;
      if (c > 0) begin
        if (mac_commit) r_commits++;
        if (mac_commit && stall_i) r_stall_commits++;
        if (done_o) begin
          r_dones++;
          if (r_done_cyc < 0) r_done_cyc = c;
        end
        if (err_o) r_errs++;
        if (!busy_o && r_idle_cyc < 0) r_idle_cyc = c;
        if (c == 1) r_rd0 = mac_predec.acc_rd_en;
        if (c == 2) r_rd1 = mac_predec.acc_rd_en;
      end
    end
    @(negedge clk);
    start_i = 0; abort_i = 0; stall_i = 0; intg_err = 0;
    operand_a_i = '0; operand_b_i = '0;
  endtask

  typedef struct {
    logic [255:0] a;
    logic [255:0] b;
    logic [511:0] exp;
  } vec_t;

  vec_t vecs [7];
  logic [511:0] held;

  initial begin
    vecs[0] = '{256'd1, 256'd1, 512'd1};
    vecs[1] = '{{256{1'b1}}, {256{1'b1}},
                {{{63{4'hF}}, 4'hE}, {{63{4'h0}}, 4'h1}}};
    vecs[2] = '{{128'h1, 128'h1}, {128'h0, {128{1'b1}}}, {256'h0, {256{1'b1}}}};
    vecs[3] = '{{1'b1, 255'b0}, 256'd2, {256'h1, 256'h0}};
    vecs[4] = '{{64'h1, 192'h0}, {64'h1, 192'h0}, {128'h1, 384'h0}};
    vecs[5] = '{{192'h0, 64'hFFFF_FFFF_FFFF_FFFF}, {192'h0, 64'hFFFF_FFFF_FFFF_FFFF},
                {384'h0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1}};
    vecs[6] = '{256'd0, {256{1'b1}}, 512'd0};

    rst_n = 0; start_i = 0; abort_i = 0; stall_i = 0; intg_err = 0;
    operand_a_i = '0; operand_b_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 512'(busy_o), 512'd0);
    chk("rst_done", 512'(done_o), 512'd0);
    chk("rst_err", 512'(err_o), 512'd0);
    chk("rst_result", result_o, 512'd0);
    chk("rst_mac_en", 512'(mac_en), 512'd0);
    chk("rst_commit", 512'(mac_commit), 512'd0);
    chk("rst_predec", 512'(mac_predec), 512'd0);
    chk("rst_op_zero", 512'(mac_op == '0), 512'd1);
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_mul(vecs[i].a, vecs[i].b, -1, 0, -1, -1, -1);
      chk($sformatf("v%0d_result", i), result_o, vecs[i].exp);
      chk($sformatf("v%0d_done_cycle", i), 512'(r_done_cyc), 512'd17);
      chk($sformatf("v%0d_commits", i), 512'(r_commits), 512'd16);
      chk($sformatf("v%0d_done_pulses", i), 512'(r_dones), 512'd1);
      chk($sformatf("v%0d_err_pulses", i), 512'(r_errs), 512'd0);
      if (i == 0) begin
        chk("step0_acc_rd_en", 512'(r_rd0), 512'd0);
        chk("step1_acc_rd_en", 512'(r_rd1), 512'd1);
        chk("idle_op_zero", 512'(mac_op == '0), 512'd1);
        chk("idle_mac_en", 512'(mac_en), 512'd0);
      end
    end

    // Abort while idle leaves everything untouched.
    held = result_o;
    @(negedge clk); abort_i = 1;
    @(negedge clk); abort_i = 0; #1;
    chk("idle_abort_busy", 512'(busy_o), 512'd0);
    chk("idle_abort_result", result_o, held);

    // Stall for 5 cycles while step 7 is issued (cycle 8).
    run_mul({128'h1, 128'h0} >> 64, 256'd3, 8, 5, -1, -1, -1);
    chk("stall_result", result_o, {384'h0, 64'h3, 64'h0});
    chk("stall_done_cycle", 512'(r_done_cyc), 512'd22);
    chk("stall_commits", 512'(r_commits), 512'd16);
    chk("stall_commit_while_stalled", 512'(r_stall_commits), 512'd0);

    // Abort at step 5 (cycle 6), then a clean multiply.
    run_mul(256'd7, 256'd9, -1, 0, 6, -1, -1);
    chk("abort_idle_cycle", 512'(r_idle_cyc), 512'd7);
    chk("abort_done_pulses", 512'(r_dones), 512'd0);
    chk("abort_err_pulses", 512'(r_errs), 512'd0);
    chk("abort_commits", 512'(r_commits), 512'd5);
    run_mul(256'd2, 256'd2, -1, 0, -1, -1, -1);
    chk("after_abort_result", result_o, 512'd4);

    // Integrity error at step 10 (cycle 11).
    run_mul(256'd5, 256'd6, -1, 0, -1, 11, -1);
    chk("intg_err_pulses", 512'(r_errs), 512'd1);
    chk("intg_done_pulses", 512'(r_dones), 512'd0);
    chk("intg_idle_cycle", 512'(r_idle_cyc), 512'd12);
    chk("intg_commits", 512'(r_commits), 512'd10);

    // Abort together with the integrity error still reports the error.
    run_mul(256'd5, 256'd6, -1, 0, 4, 4, -1);
    chk("intg_abort_err_pulses", 512'(r_errs), 512'd1);
    chk("intg_abort_done_pulses", 512'(r_dones), 512'd0);

    // Start and abort together while idle: start wins.
    run_mul(256'd11, 256'd13, -1, 0, 0, -1, -1);
    chk("start_abort_done_cycle", 512'(r_done_cyc), 512'd17);
    chk("start_abort_result", result_o, 512'd143);

    // Start re-pulsed at step 3 with different operands is ignored.
    run_mul(256'd3, 256'd5, -1, 0, -1, -1, 4);
    chk("restart_done_pulses", 512'(r_dones), 512'd1);
    chk("restart_commits", 512'(r_commits), 512'd16);
    chk("restart_result", result_o, 512'd15);
    chk("restart_busy_after", 512'(busy_o), 512'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
